nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder.sv | 98 +++++++++
 tb/tb_nibble_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder: request side (a, b, carryin) and result side (sum, carryout).
// The master drives operands and consumes results; the slave is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;

  modport master (
    output in_valid, a, b, carryin, out_ready,
    input  in_ready, out_valid, sum, carryout
  );

  modport slave (
    input  in_valid, a, b, carryin, out_ready,
    output in_ready, out_valid, sum, carryout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit slice; out_valid rises NIB edges after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready, so back-pressure stalls the block.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus,
  output logic                  busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [IW-1:0]    idx_q;

  logic [IW+1:0]    shamt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [4:0]       slice;

  // The current nibble is brought down to bit 0 so one 4-bit slice serves every position.
  assign shamt = {idx_q, 2'b00};
  assign a_sh  = a_q >> shamt;
  assign b_sh  = b_q >> shamt;
  assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (idx_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carryin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
          end
        end
        ADD: begin
          // sum was cleared on accept, so OR-ing places each nibble without a read-modify mask.
          sum_q   <= sum_q | (WIDTH'(slice[3:0]) << shamt);
          carry_q <= slice[4];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) cout_q <= slice[4];
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.carryout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an arithmetic reference {cout,sum} = a + b + cin.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] r;
    r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    return r;
  endfunction

  // Presents one operand pair for a single accepting edge; returns just after that edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carryin  = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept until out_valid, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.sum !== '0 || bus.carryout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b sum=%h cout=%b exp rdy=1 vld=0 busy=0 sum=0000 cout=0",
               bus.in_ready, bus.out_valid, busy, bus.sum, bus.carryout);
    end
  endtask

  task automatic test_basic();
    int e;
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(e);
    checks++;
    if (e !== NIB) begin
      errors++;
      $display("FAIL basic_latency got %0d exp %0d", e, NIB);
    end
    checks++;
    if (bus.sum !== 16'h5555 || bus.carryout !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got %h/%b exp 5555/0", bus.sum, bus.carryout);
    end
    consume();
  endtask

  task automatic test_carry_chain();
    int e;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(e);
    checks++;
    if (bus.sum !== 16'h0000 || bus.carryout !== 1'b1 || e !== NIB) begin
      errors++;
      $display("FAIL carry_b1 got %h/%b lat %0d exp 0000/1 lat %0d", bus.sum, bus.carryout, e, NIB);
    end
    consume();
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done(e);
    checks++;
    if (bus.sum !== 16'h0000 || bus.carryout !== 1'b1) begin
      errors++;
      $display("FAIL carry_cin got %h/%b exp 0000/1", bus.sum, bus.carryout);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int e;
    start_op(16'h00F0, 16'h0010, 1'b0);
    wait_done(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0100 || bus.carryout !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got vld=%b sum=%h cout=%b rdy=%b exp 1/0100/0/0",
                 i, bus.out_valid, bus.sum, bus.carryout, bus.in_ready);
      end
    end
    consume();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got rdy=%b vld=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_busy_reject();
    int e;
    start_op(16'h0001, 16'h0001, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.carryin  = 1'b1;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_flag got busy=%b rdy=%b exp 1/0", busy, bus.in_ready);
    end
    wait_done(e);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.sum !== 16'h0002 || bus.carryout !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject_sum got %h/%b exp 0002/0", bus.sum, bus.carryout);
    end
    consume();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_no_second_op got busy=%b rdy=%b exp 0/1", busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_midop();
    int e;
    start_op(16'h8000, 16'h8000, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.sum !== '0 || bus.carryout !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop got rdy=%b vld=%b busy=%b sum=%h cout=%b exp 1/0/0/0000/0",
               bus.in_ready, bus.out_valid, busy, bus.sum, bus.carryout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done(e);
    checks++;
    if (bus.sum !== 16'h0000 || bus.carryout !== 1'b1 || e !== NIB) begin
      errors++;
      $display("FAIL reset_fresh_op got %h/%b lat %0d exp 0000/1 lat %0d", bus.sum, bus.carryout, e, NIB);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] s1;
    logic             c1;
    int               k;
    int               sep;
    int               e;
    logic             got1;
    got1 = 1'b0;
    sep  = -1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h7FFF;
    bus.b         = 16'h0001;
    bus.carryin   = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 16'h0003;
    bus.b = 16'h0004;
    k = 0;
    while (sep < 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.out_valid && !got1) begin
        s1   = bus.sum;
        c1   = bus.carryout;
        got1 = 1'b1;
      end
      if (bus.in_ready) sep = k + 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (!got1 || s1 !== 16'h8000 || c1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got seen=%b %h/%b exp 8000/0", got1, s1, c1);
    end
    checks++;
    if (sep !== NIB + 2) begin
      errors++;
      $display("FAIL b2b_spacing got %0d exp %0d", sep, NIB + 2);
    end
    e = 0;
    while (!bus.out_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0007 || bus.carryout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got vld=%b %h/%b exp 1/0007/0", bus.out_valid, bus.sum, bus.carryout);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH:0]   exp;
    int               e;
    for (int n = 0; n < 24; n++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rc  = 1'($urandom_range(0, 1));
      exp = ref_add(ra, rb, rc);
      start_op(ra, rb, rc);
      wait_done(e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.carryout, bus.sum} !== exp) begin
        errors++;
        $display("FAIL random[%0d] %h+%h+%b got vld=%b %b/%h exp 1/%b/%h", n, ra, rb, rc,
                 bus.out_valid, bus.carryout, bus.sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      consume();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carryin   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_busy_reject();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
